// File: rtl/game_pkg.sv
// Shared constants and state encoding for the game command sequencer.
// Pure declarations: no logic, no latency, no flow control.
package game_pkg;

  localparam logic [7:0] SYNC_DRAW  = 8'hA5;
  localparam logic [7:0] SYNC_CLEAR = 8'h5A;

  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 24;

  typedef enum logic [2:0] {
    IDLE,
    GET_X,
    GET_Y,
    GET_COL,
    GET_CHK,
    WRITE,
    CLEAR
  } state_t;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: expired is high after TIMEOUT_CYC enabled clocks without restart.
// Latency: expired rises in the TIMEOUT_CYC-th cycle after the last restart; no backpressure.
module byte_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart || !enable) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/game_cmd_sequencer.sv
// Decodes UART draw/clear packets into frame-buffer cell writes.
// Latency: fb_req one cycle after CHK; fb_req held (addr/data stable) until fb_ack.
module game_cmd_sequencer
  import game_pkg::*;
#(
  parameter int GRID_W      = GRID_W_DEF,
  parameter int GRID_H      = GRID_H_DEF,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              fb_req,
  input  logic              fb_ack,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              busy,
  output logic              pkt_ok,
  output logic              pkt_err
);

  localparam int                AW_FULL   = ADDR_W + 8;
  localparam logic [31:0]       GW        = 32'(GRID_W);
  localparam logic [31:0]       GH        = 32'(GRID_H);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(GRID_W * GRID_H - 1);

  state_t              state, state_nxt;
  logic [7:0]          x_q, y_q, col_q;
  logic [ADDR_W-1:0]   fb_addr_q;
  logic [7:0]          fb_data_q;
  logic                err_pend, err_pend_nxt;
  logic                in_get, expired, chk_bad, done;
  logic [ADDR_W-1:0]   addr_calc;

  assign in_get    = (state == GET_X) || (state == GET_Y) || (state == GET_COL) || (state == GET_CHK);
  assign chk_bad   = (rx_data != (x_q ^ y_q ^ col_q)) || (32'(x_q) >= GW) || (32'(y_q) >= GH);
  assign addr_calc = ADDR_W'(AW_FULL'(y_q) * AW_FULL'(GRID_W) + AW_FULL'(x_q));
  assign done      = fb_ack && ((state == WRITE) || ((state == CLEAR) && (fb_addr_q == LAST_CELL)));

  byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (CLOCK_50),
    .rst     (rst),
    .restart (rx_valid),
    .enable  (in_get),
    .expired (expired)
  );

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      col_q     <= '0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      err_pend  <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_pend <= err_pend_nxt;
      if (rx_valid) begin
        case (state)
          IDLE: if (rx_data == SYNC_CLEAR) begin
            fb_addr_q <= '0;
            fb_data_q <= '0;
          end
          GET_X:   x_q   <= rx_data;
          GET_Y:   y_q   <= rx_data;
          GET_COL: col_q <= rx_data;
          GET_CHK: if (!chk_bad) begin
            fb_addr_q <= addr_calc;
            fb_data_q <= col_q;
          end
          default: ;
        endcase
      end
      if ((state == CLEAR) && fb_ack && (fb_addr_q != LAST_CELL)) begin
        fb_addr_q <= fb_addr_q + 1'b1;
      end
    end
  end

  // A byte that collides with the completing ack has its error deferred to the
  // following IDLE cycle so pkt_ok and pkt_err never coincide.
  always_comb begin
    state_nxt    = state;
    err_pend_nxt = 1'b0;
    pkt_ok       = 1'b0;
    pkt_err      = err_pend;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_DRAW)) state_nxt = GET_X;
        else if (rx_valid && (rx_data == SYNC_CLEAR)) state_nxt = CLEAR;
      end
      GET_X, GET_Y, GET_COL: begin
        if (rx_valid) begin
          state_nxt = state_t'(state + 3'd1);
        end else if (expired) begin
          state_nxt = IDLE;
          pkt_err   = 1'b1;
        end
      end
      GET_CHK: begin
        if (rx_valid) begin
          state_nxt = chk_bad ? IDLE : WRITE;
          pkt_err   = chk_bad;
        end else if (expired) begin
          state_nxt = IDLE;
          pkt_err   = 1'b1;
        end
      end
      WRITE, CLEAR: begin
        if (done) begin
          state_nxt    = IDLE;
          pkt_ok       = 1'b1;
          err_pend_nxt = rx_valid;
        end else if (rx_valid) begin
          pkt_err = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      pkt_ok  = 1'b0;
      pkt_err = 1'b0;
    end
  end

  assign fb_req  = (state == WRITE) || (state == CLEAR);
  assign busy    = (state != IDLE);
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;

endmodule

// File: tb/tb_game_cmd_sequencer.sv
// Directed vector table plus hand sequences for clear sweep, timeout and reset abort.
module tb_game_cmd_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       fb_req;
  logic       fb_ack;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       busy;
  logic       pkt_ok;
  logic       pkt_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ack;
    logic [3:0] flags;  // {fb_req, busy, pkt_ok, pkt_err}
    logic [9:0] addr;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs[$];

  game_cmd_sequencer dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .fb_req   (fb_req),
    .fb_ack   (fb_ack),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .busy     (busy),
    .pkt_ok   (pkt_ok),
    .pkt_err  (pkt_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic vec_t mk(logic v, logic [7:0] d, logic ack, logic [3:0] flags,
                              logic [9:0] addr, logic [7:0] dat);
    vec_t r;
    r.v = v; r.d = d; r.ack = ack; r.flags = flags; r.addr = addr; r.dat = dat;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic ack);
    @(posedge CLOCK_50);
    #1;
    rx_valid = v;
    rx_data  = d;
    fb_ack   = ack;
    @(negedge CLOCK_50);
  endtask

  initial begin
    int writes, reqs, oks, errs, order_bad, exp_a, last_ok_addr, err_at;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; fb_ack = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("reset_outputs", {fb_req, busy, pkt_ok, pkt_err, fb_addr, fb_data}, 32'h0);
    @(posedge CLOCK_50);
    #1 rst = 1'b0;
    @(negedge CLOCK_50);

    // good draw, bad checksum, X out of range, noise byte, draw with late ack and stray bytes
    vecs.push_back(mk(1, 8'hA5, 1, 4'b0000, 10'd0,   8'h00));
    vecs.push_back(mk(1, 8'h03, 1, 4'b0100, 10'd0,   8'h00));
    vecs.push_back(mk(1, 8'h02, 1, 4'b0100, 10'd0,   8'h00));
    vecs.push_back(mk(1, 8'h07, 1, 4'b0100, 10'd0,   8'h00));
    vecs.push_back(mk(1, 8'h06, 1, 4'b0100, 10'd0,   8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 4'b1110, 10'd67,  8'h07));
    vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'hA5, 1, 4'b0000, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h03, 1, 4'b0100, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h02, 1, 4'b0100, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h07, 1, 4'b0100, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h05, 1, 4'b0101, 10'd67,  8'h07));
    vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'hA5, 1, 4'b0000, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h20, 1, 4'b0100, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h00, 1, 4'b0100, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h01, 1, 4'b0100, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h21, 1, 4'b0101, 10'd67,  8'h07));
    vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h33, 1, 4'b0000, 10'd67,  8'h07));
    vecs.push_back(mk(0, 8'h00, 1, 4'b0000, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'hA5, 0, 4'b0000, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h1F, 0, 4'b0100, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'h17, 0, 4'b0100, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'hFF, 0, 4'b0100, 10'd67,  8'h07));
    vecs.push_back(mk(1, 8'hF7, 0, 4'b0100, 10'd67,  8'h07));
    vecs.push_back(mk(0, 8'h00, 0, 4'b1100, 10'd767, 8'hFF));
    vecs.push_back(mk(1, 8'h12, 0, 4'b1101, 10'd767, 8'hFF));
    vecs.push_back(mk(1, 8'h44, 1, 4'b1110, 10'd767, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 4'b0001, 10'd767, 8'hFF));
    vecs.push_back(mk(0, 8'h00, 0, 4'b0000, 10'd767, 8'hFF));

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].ack);
      check($sformatf("vec%0d", i), {fb_req, busy, pkt_ok, pkt_err, fb_addr, fb_data},
            {vecs[i].flags, vecs[i].addr, vecs[i].dat});
    end

    // clear sweep, ack on alternate cycles starting with the first CLEAR cycle
    writes = 0; reqs = 0; oks = 0; errs = 0; order_bad = 0; exp_a = 0; last_ok_addr = -1;
    step(1, 8'h5A, 0);
    for (int k = 0; k < 2000; k++) begin
      step(0, 8'h00, (k % 2) == 0);
      if (!fb_req) break;
      reqs++;
      if (fb_ack) begin
        if (fb_addr !== 10'(exp_a) || fb_data !== 8'h00) order_bad++;
        exp_a++;
        writes++;
      end
      if (pkt_ok) begin
        oks++;
        last_ok_addr = int'(fb_addr);
      end
      if (pkt_err) errs++;
    end
    check("clear_writes", writes, 768);
    check("clear_req_cycles", reqs, 1535);
    check("clear_pkt_ok", oks, 1);
    check("clear_order", order_bad, 0);
    check("clear_no_err", errs, 0);
    check("clear_ok_at_last", last_ok_addr, 767);
    check("clear_no_wrap", {busy, fb_addr}, {1'b0, 10'd767});

    // inter-byte timeout after A5,03
    err_at = 0;
    step(1, 8'hA5, 1);
    step(1, 8'h03, 1);
    for (int k = 1; k <= 50010; k++) begin
      step(0, 8'h00, 1);
      if (pkt_err) begin
        err_at = k;
        break;
      end
    end
    check("timeout_cycle", err_at, 50000);
    step(0, 8'h00, 1);
    check("timeout_idle", {busy, pkt_err}, 2'b00);
    step(1, 8'hA5, 1);
    step(1, 8'h01, 1);
    step(1, 8'h01, 1);
    step(1, 8'h05, 1);
    step(1, 8'h05, 1);
    step(0, 8'h00, 1);
    check("post_timeout_draw", {fb_req, pkt_ok, pkt_err, fb_addr, fb_data},
          {3'b110, 10'd33, 8'h05});

    // stray byte during stalled CLEAR, then reset mid-sweep
    step(1, 8'h5A, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    check("stall_addr", {fb_req, fb_addr}, {1'b1, 10'd3});
    step(1, 8'h9C, 0);
    check("clear_rx_err", {fb_req, pkt_ok, pkt_err, fb_addr}, {3'b101, 10'd3});
    step(0, 8'h00, 0);
    check("clear_undisturbed", {fb_req, pkt_err, fb_addr}, {2'b10, 10'd3});
    @(posedge CLOCK_50);
    #1;
    rst = 1'b1;
    fb_ack = 1'b1;
    @(negedge CLOCK_50);
    check("rst_no_pulse", {pkt_ok, pkt_err}, 2'b00);
    @(posedge CLOCK_50);
    #1;
    rst = 1'b0;
    fb_ack = 1'b0;
    @(negedge CLOCK_50);
    check("rst_abort", {fb_req, busy, pkt_ok, fb_addr}, {3'b000, 10'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
